// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: forwarding selects, FSM encodings
// and the upstream control bundle driven back into the pipeline.
package hazard_ctrl_pkg;

   localparam int DEF_RFIDX_WIDTH = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] HZ_RUN     = 2'd0;
   localparam logic [1:0] HZ_FLUSH   = 2'd1;
   localparam logic [1:0] HZ_MEMWAIT = 2'd2;

   typedef struct packed {
      logic pc_write_en;
      logic if_id_write_en;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_hold;
   } ctrl_t;

   localparam ctrl_t CTRL_NORMAL = 5'b11000;
   localparam ctrl_t CTRL_FREEZE = 5'b00001;
   localparam ctrl_t CTRL_FLUSH  = 5'b11110;
   localparam ctrl_t CTRL_STALL  = 5'b00010;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// master = pipeline (drives stage info), slave = hazard controller.
interface hazard_ctrl_if #(
   parameter int RFIDX_WIDTH = 5,
   parameter int CNT_WIDTH   = 16
);
   logic [RFIDX_WIDTH-1:0] id_rs1_index;
   logic [RFIDX_WIDTH-1:0] id_rs2_index;
   logic                   id_uses_rs1;
   logic                   id_uses_rs2;
   logic [RFIDX_WIDTH-1:0] ex_rs1_index;
   logic [RFIDX_WIDTH-1:0] ex_rs2_index;
   logic [RFIDX_WIDTH-1:0] ex_rd_index;
   logic                   ex_mem_read;
   logic                   ex_take;
   logic                   ex_branch_taken;
   logic                   ex_branch;
   logic [RFIDX_WIDTH-1:0] mem_rd_index;
   logic                   mem_reg_write;
   logic [RFIDX_WIDTH-1:0] wb_rd_index;
   logic                   wb_reg_write;
   logic                   dmem_req;
   logic                   dmem_ready;
   logic                   pc_write_en;
   logic                   if_id_write_en;
   logic                   if_id_flush;
   logic                   id_ex_bubble;
   logic                   ex_mem_hold;
   logic [1:0]             fwd_a_sel;
   logic [1:0]             fwd_b_sel;
   logic                   mem_timeout;
   logic [CNT_WIDTH-1:0]   stall_count;

   modport master (
      output id_rs1_index, id_rs2_index, id_uses_rs1, id_uses_rs2,
             ex_rs1_index, ex_rs2_index, ex_rd_index, ex_mem_read,
             ex_take, ex_branch_taken, ex_branch,
             mem_rd_index, mem_reg_write, wb_rd_index, wb_reg_write,
             dmem_req, dmem_ready,
      input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
             ex_mem_hold, fwd_a_sel, fwd_b_sel, mem_timeout, stall_count
   );

   modport slave (
      input  id_rs1_index, id_rs2_index, id_uses_rs1, id_uses_rs2,
             ex_rs1_index, ex_rs2_index, ex_rd_index, ex_mem_read,
             ex_take, ex_branch_taken, ex_branch,
             mem_rd_index, mem_reg_write, wb_rd_index, wb_reg_write,
             dmem_req, dmem_ready,
      output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
             ex_mem_hold, fwd_a_sel, fwd_b_sel, mem_timeout, stall_count
   );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register.
// The younger MEM result wins over WB; x0 is never forwarded.
module fwd_unit
   import hazard_ctrl_pkg::*;
#(
   parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH
) (
   input  logic [RFIDX_WIDTH-1:0] i_ex_rs_index,
   input  logic [RFIDX_WIDTH-1:0] i_mem_rd_index,
   input  logic                   i_mem_reg_write,
   input  logic [RFIDX_WIDTH-1:0] i_wb_rd_index,
   input  logic                   i_wb_reg_write,
   output logic [1:0]             o_fwd_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem_reg_write && (i_mem_rd_index != '0) &&
                      (i_mem_rd_index == i_ex_rs_index);
   assign w_wb_hit  = i_wb_reg_write && (i_wb_rd_index != '0) &&
                      (i_wb_rd_index == i_ex_rs_index);

   always_comb begin
      o_fwd_sel = FWD_RF;
      if (w_mem_hit)
         o_fwd_sel = FWD_MEM;
      else if (w_wb_hit)
         o_fwd_sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, mispredict flush, dmem freeze with
// watchdog, operand forwarding and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int RFIDX_WIDTH  = DEF_RFIDX_WIDTH,
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 255,
   parameter int CNT_WIDTH    = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave hz
);

   localparam int               WAIT_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
   localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   logic [1:0]           r_state;
   logic [1:0]           w_state_next;
   logic [2:0]           r_flush_cnt;
   logic [2:0]           w_flush_cnt_next;
   logic [WAIT_W-1:0]    r_wait_cnt;
   logic [WAIT_W-1:0]    w_wait_cnt_next;
   logic                 r_mem_timeout;
   logic                 w_mem_timeout_next;
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   logic  w_mem_wait;
   logic  w_mispredict;
   logic  w_load_use;
   ctrl_t w_ctrl;
   ctrl_t w_ctrl_out;

   logic [RFIDX_WIDTH-1:0] w_ex_rs [2];
   logic [1:0]             w_fwd_sel [2];

   assign w_mem_wait   = hz.dmem_req && !hz.dmem_ready;
   assign w_mispredict = hz.ex_branch && (hz.ex_branch_taken != hz.ex_take);
   assign w_load_use   = hz.ex_mem_read && (hz.ex_rd_index != '0) &&
                         ((hz.id_uses_rs1 && (hz.id_rs1_index == hz.ex_rd_index)) ||
                          (hz.id_uses_rs2 && (hz.id_rs2_index == hz.ex_rd_index)));

   always_comb begin
      w_state_next     = r_state;
      w_flush_cnt_next = r_flush_cnt;
      w_ctrl           = CTRL_NORMAL;
      case (r_state)
         HZ_FLUSH: begin
            if (w_mem_wait) begin
               w_ctrl           = CTRL_FREEZE;
               w_state_next     = HZ_MEMWAIT;
               w_flush_cnt_next = '0;
            end else begin
               w_ctrl = CTRL_FLUSH;
               if (r_flush_cnt <= 3'd1) begin
                  w_state_next     = HZ_RUN;
                  w_flush_cnt_next = '0;
               end else begin
                  w_flush_cnt_next = r_flush_cnt - 3'd1;
               end
            end
         end
         HZ_MEMWAIT: begin
            if (w_mem_wait) begin
               w_ctrl = CTRL_FREEZE;
            end else begin
               // Release cycle: the held branch re-resolves next cycle in RUN,
               // but a load-use pair must still be separated now.
               w_state_next = HZ_RUN;
               if (w_load_use)
                  w_ctrl = CTRL_STALL;
            end
         end
         default: begin
            if (w_mem_wait) begin
               w_ctrl       = CTRL_FREEZE;
               w_state_next = HZ_MEMWAIT;
            end else if (w_mispredict) begin
               w_ctrl = CTRL_FLUSH;
               if (FLUSH_CYCLES > 1) begin
                  w_state_next     = HZ_FLUSH;
                  w_flush_cnt_next = FLUSH_LOAD;
               end
            end else if (w_load_use) begin
               w_ctrl = CTRL_STALL;
            end
         end
      endcase
   end

   always_comb begin
      w_wait_cnt_next = '0;
      if (w_mem_wait)
         w_wait_cnt_next = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
      w_mem_timeout_next = r_mem_timeout || (w_mem_wait && (w_wait_cnt_next == WAIT_MAX));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= HZ_RUN;
         r_flush_cnt   <= '0;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
         r_stall_cnt   <= '0;
      end else begin
         r_state       <= w_state_next;
         r_flush_cnt   <= w_flush_cnt_next;
         r_wait_cnt    <= w_wait_cnt_next;
         r_mem_timeout <= w_mem_timeout_next;
         if (!w_ctrl_out.pc_write_en && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign w_ex_rs[0] = hz.ex_rs1_index;
   assign w_ex_rs[1] = hz.ex_rs2_index;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_unit #(
            .RFIDX_WIDTH (RFIDX_WIDTH)
         ) u_fwd (
            .i_ex_rs_index   (w_ex_rs[gi]),
            .i_mem_rd_index  (hz.mem_rd_index),
            .i_mem_reg_write (hz.mem_reg_write),
            .i_wb_rd_index   (hz.wb_rd_index),
            .i_wb_reg_write  (hz.wb_reg_write),
            .o_fwd_sel       (w_fwd_sel[gi])
         );
      end
   endgenerate

   // Outputs are held at their idle values for as long as reset is asserted.
   assign w_ctrl_out = rst_n ? w_ctrl : CTRL_NORMAL;

   assign hz.pc_write_en    = w_ctrl_out.pc_write_en;
   assign hz.if_id_write_en = w_ctrl_out.if_id_write_en;
   assign hz.if_id_flush    = w_ctrl_out.if_id_flush;
   assign hz.id_ex_bubble   = w_ctrl_out.id_ex_bubble;
   assign hz.ex_mem_hold    = w_ctrl_out.ex_mem_hold;
   assign hz.fwd_a_sel      = rst_n ? w_fwd_sel[0] : FWD_RF;
   assign hz.fwd_b_sel      = rst_n ? w_fwd_sel[1] : FWD_RF;
   assign hz.mem_timeout    = r_mem_timeout;
   assign hz.stall_count    = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Consumes the EX-side outputs of the decode/execute pipeline register, plus the ID, MEM and WB stage indices.
- Drives control back upstream: PC write enable, IF/ID write/flush, ID/EX bubble insertion, EX/MEM hold and operand forwarding selects.
- Owns load-use stall, branch-mispredict flush, data-memory wait freeze with timeout watchdog, and a stall performance counter.

Parameters:
RFIDX_WIDTH, 5, register-file index width
FLUSH_CYCLES, 1, cycles of flush after a mispredict (1..7)
MEM_TIMEOUT, 255, consecutive dmem wait cycles before mem_timeout sets
CNT_WIDTH, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1_index  in  RFIDX_WIDTH  rs1 of instruction in ID
id_rs2_index  in  RFIDX_WIDTH  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rs1_index  in  RFIDX_WIDTH  rs1 of instruction in EX
ex_rs2_index  in  RFIDX_WIDTH  rs2 of instruction in EX
ex_rd_index  in  RFIDX_WIDTH  rd in EX
ex_mem_read  in  1  EX instruction is a load
ex_take  in  1  predicted-taken flag carried with EX instruction
ex_branch_taken  in  1  branch outcome resolved in EX
ex_branch  in  1  EX instruction is a branch
mem_rd_index  in  RFIDX_WIDTH  rd in MEM
mem_reg_write  in  1  MEM writes rd
wb_rd_index  in  RFIDX_WIDTH  rd in WB
wb_reg_write  in  1  WB writes rd
dmem_req  in  1  MEM stage memory access active
dmem_ready  in  1  data memory completes access this cycle
pc_write_en  out  1  PC may update
if_id_write_en  out  1  IF/ID may capture
if_id_flush  out  1  IF/ID loads NOP
id_ex_bubble  out  1  ID/EX loads all-zero control
ex_mem_hold  out  1  EX/MEM and later stages hold
fwd_a_sel  out  2  ALU operand A source
fwd_b_sel  out  2  ALU operand B source
mem_timeout  out  1  sticky watchdog error
stall_count  out  CNT_WIDTH  saturating stall-cycle count

Behaviour:
- Clock port is clk; reset port is rst_n. Reset is asynchronous, active-low, one clock domain.
- Reset values: state=RUN, flush counter=0, wait counter=0, mem_timeout=0, stall_count=0.
- While rst_n=0, outputs are pc_write_en=1, if_id_write_en=1, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=0, fwd_*=00.
- Outputs are combinational from state plus inputs (Mealy); hazards act in the detection cycle with zero latency.
- mispredict = ex_branch & (ex_branch_taken != ex_take).
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- mem_wait = dmem_req & ~dmem_ready.
- Priority per cycle: mem_wait > mispredict > load_use.
- mem_wait: pc_write_en=0, if_id_write_en=0, ex_mem_hold=1, no flush, no bubble.
- mispredict: if_id_flush=1, id_ex_bubble=1, pc_write_en=1 so the redirect target loads.
- load_use: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for exactly one cycle; the condition clears naturally once the bubble enters EX.
- State machine:
  - RUN: mem_wait -> MEM_WAIT; else mispredict with FLUSH_CYCLES>1 -> FLUSH, counter=FLUSH_CYCLES-1; else stay.
  - FLUSH: asserts if_id_flush=1 and id_ex_bubble=1; load_use and mispredict are ignored. Counter decrements each cycle; ->RUN when it reaches 1 and that cycle completes. mem_wait preempts: go to MEM_WAIT and discard the remaining flush.
  - MEM_WAIT: freeze outputs as above; the wait counter increments per cycle. When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset; state remains MEM_WAIT. Transition to RUN on dmem_ready or ~dmem_req; the wait counter clears on exit.
- A mispredict that arrives while frozen persists in EX and is acted on in the first RUN cycle after the freeze.
- Forwarding (EX operands):
  - 10 when mem_reg_write & mem_rd!=0 & mem_rd==ex_rs.
  - Else 01 when wb_reg_write & wb_rd!=0 & wb_rd==ex_rs.
  - Else 00.
  - MEM wins over WB. x0 is never forwarded.
- stall_count increments on any cycle with pc_write_en=0 and saturates at all ones with no wrap.

Decomposition:
- Shared in defines.v:
  - RFIDX_WIDTH.
  - Forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - State encodings HZ_RUN, HZ_FLUSH, HZ_MEMWAIT.
- Sub-module fwd_unit: purely combinational forwarding; two instances, one per operand.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_write_en=0, id_ex_bubble=1; next cycle (ex_mem_read=0) all normal; stall_count=1.
- Mispredict: ex_branch=1, ex_take=0, ex_branch_taken=1, FLUSH_CYCLES=2 -> if_id_flush=1 and id_ex_bubble=1 for 2 cycles; a simultaneous load_use is ignored; pc_write_en stays 1.
- Forward priority: mem_rd=wb_rd=ex_rs1=7, both write -> fwd_a_sel=10. With ex_rs2=0 and wb_rd=0 -> fwd_b_sel=00.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles concurrent with mispredict -> freeze for 3 cycles, no flush; the flush asserts the cycle after dmem_ready=1.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 after the 4th wait cycle; it stays 1 after ready and clears only on rst_n=0.
- Reset mid-FLUSH and at CNT_WIDTH=4 saturation: rst_n pulse -> state RUN and all outputs at reset values; 20 stall cycles -> stall_count=15.
